// File: rtl/led_pwm_pkg.sv
// Shared constants for the led_pwm_bank register window.
package led_pwm_pkg;

  // Byte offsets from the window base
  localparam logic [31:0] OFF_CTRL      = 32'h0000_0000;
  localparam logic [31:0] OFF_PRESCALE  = 32'h0000_0004;
  localparam logic [31:0] OFF_STATUS    = 32'h0000_0008;
  localparam logic [31:0] OFF_BLINK     = 32'h0000_000C;
  localparam logic [31:0] OFF_DUTY_BASE = 32'h0000_0010;

  // CTRL field positions
  localparam int unsigned CTRL_GEN_BIT  = 0;
  localparam int unsigned CTRL_CHEN_LSB = 8;

  // STATUS field positions
  localparam int unsigned STATUS_WRAP_BIT = 0;

  // BLINK field positions (mask occupies the low CHANNELS bits)
  localparam int unsigned BLINK_HALF_LSB  = 16;
  localparam int unsigned BLINK_HALF_BITS = 8;

  // Byte offset of the DUTY register for channel ch
  function automatic logic [31:0] duty_off(input int unsigned ch);
    return OFF_DUTY_BASE + 32'(4 * ch);
  endfunction

endpackage

// File: rtl/led_pwm_bank_if.sv
// CPU simple read/write bus as seen by the PWM bank.
interface led_pwm_bank_if;
  logic        write;
  logic        read;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output write, read, address, wdata, input rdata);
  modport slave  (input write, read, address, wdata, output rdata);
endinterface

// File: rtl/led_pwm_channel.sv
// One PWM channel: shadow/active duty, compare and registered active-low pin.
module led_pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gen_i,
  input  logic                chen_i,
  input  logic                wrap_i,
  input  logic                force_off_i,
  input  logic                duty_we_i,
  input  logic [PWM_BITS-1:0] duty_wdata_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  output logic [PWM_BITS-1:0] shadow_o,
  output logic                led_n_o
);

  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

  logic [PWM_BITS-1:0] shadow_q;
  logic [PWM_BITS-1:0] active_q;
  logic                led_n_q;
  logic                lit_c;

  // CPU-visible shadow duty
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            shadow_q <= '0;
    else if (duty_we_i) shadow_q <= duty_wdata_i;
  end

  // Active duty only changes at a period wrap (or freely while stopped)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   active_q <= '0;
    else if (!gen_i || wrap_i) active_q <= shadow_q;
  end

  assign lit_c = gen_i & chen_i & ~force_off_i &
                 ((cnt_i < active_q) | (active_q == DUTY_FULL));

  // Registered active-low pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_n_q <= 1'b1;
    else     led_n_q <= ~lit_c;
  end

  assign shadow_o = shadow_q;
  assign led_n_o  = led_n_q;

endmodule

// File: rtl/led_pwm_bank.sv
// Memory-mapped multi-channel PWM LED controller.
// Optional blink feature enabled by defining LED_PWM_BLINK_EN.
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESCALE_BITS = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  led_pwm_bank_if.slave       bus,
  output logic [CHANNELS-1:0] led_n,
  output logic                period_tick
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [31:0]              offset_c;
  logic                     sel_ctrl_c;
  logic                     sel_prescale_c;
  logic                     sel_status_c;
  logic [CHANNELS-1:0]      duty_sel_c;
  logic [31:0]              rdata_c;
  logic                     tick_c;
  logic                     wrap_c;
  logic [CHANNELS-1:0]      force_off_c;
  logic [PWM_BITS-1:0]      duty_shadow [CHANNELS];

  logic                     gen_q;
  logic [CHANNELS-1:0]      chen_q;
  logic [PRESCALE_BITS-1:0] prescale_q;
  logic [PRESCALE_BITS-1:0] pre_cnt_q;
  logic [PWM_BITS-1:0]      cnt_q;
  logic                     wrap_sticky_q;
  logic                     period_tick_q;
  logic [31:0]              rdata_q;
  logic                     unused_c;

  // Address decode on the word-aligned offset into the window
  assign offset_c       = (bus.address & ~32'h3) - (BASE_ADDR & ~32'h3);
  assign sel_ctrl_c     = (offset_c == OFF_CTRL);
  assign sel_prescale_c = (offset_c == OFF_PRESCALE);
  assign sel_status_c   = (offset_c == OFF_STATUS);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_dsel
    assign duty_sel_c[i] = (offset_c == duty_off(i));
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_q      <= 1'b0;
      chen_q     <= '0;
      prescale_q <= '0;
    end else if (bus.write) begin
      if (sel_ctrl_c) begin
        gen_q  <= bus.wdata[CTRL_GEN_BIT];
        chen_q <= bus.wdata[CTRL_CHEN_LSB +: CHANNELS];
      end
      if (sel_prescale_c) prescale_q <= bus.wdata[PRESCALE_BITS-1:0];
    end
  end

  // >= keeps the prescaler bounded if PRESCALE is lowered mid-count
  assign tick_c = gen_q && (pre_cnt_q >= prescale_q);
  assign wrap_c = tick_c && (cnt_q == CNT_MAX);

  // Prescaler and PWM counter, parked at zero while GEN is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
    end else if (!gen_q) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
    end else if (tick_c) begin
      pre_cnt_q <= '0;
      cnt_q     <= PWM_BITS'(cnt_q + 1'b1);
    end else begin
      pre_cnt_q <= PRESCALE_BITS'(pre_cnt_q + 1'b1);
    end
  end

  // Sticky WRAP flag; a wrap beats a simultaneous write-1-clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wrap_sticky_q <= 1'b0;
    else if (wrap_c) wrap_sticky_q <= 1'b1;
    else if (bus.write && sel_status_c && bus.wdata[STATUS_WRAP_BIT])
      wrap_sticky_q <= 1'b0;
  end

  // Period wrap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) period_tick_q <= 1'b0;
    else     period_tick_q <= wrap_c;
  end

`ifdef LED_PWM_BLINK_EN
  logic                       sel_blink_c;
  logic [CHANNELS-1:0]        blink_mask_q;
  logic [BLINK_HALF_BITS-1:0] blink_half_q;
  logic [BLINK_HALF_BITS-1:0] blink_cnt_q;
  logic                       blink_off_q;

  assign sel_blink_c = (offset_c == OFF_BLINK);

  // Blink phase: counts wraps, toggles every half-period, restarts on write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_mask_q <= '0;
      blink_half_q <= '0;
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
    end else if (bus.write && sel_blink_c) begin
      blink_mask_q <= bus.wdata[CHANNELS-1:0];
      blink_half_q <= bus.wdata[BLINK_HALF_LSB +: BLINK_HALF_BITS];
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
    end else if (wrap_c && (blink_half_q != '0)) begin
      if (blink_cnt_q == BLINK_HALF_BITS'(blink_half_q - 1'b1)) begin
        blink_cnt_q <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        blink_cnt_q <= BLINK_HALF_BITS'(blink_cnt_q + 1'b1);
      end
    end
  end

  assign force_off_c = blink_mask_q &
                       {CHANNELS{blink_off_q && (blink_half_q != '0)}};
`else
  assign force_off_c = '0;
`endif

  // Read data mux; unmapped offsets and unused field bits read 0
  always_comb begin
    rdata_c = '0;
    if (sel_ctrl_c) begin
      rdata_c[CTRL_GEN_BIT]              = gen_q;
      rdata_c[CTRL_CHEN_LSB +: CHANNELS] = chen_q;
    end
    if (sel_prescale_c) rdata_c[PRESCALE_BITS-1:0] = prescale_q;
    if (sel_status_c)   rdata_c[STATUS_WRAP_BIT]   = wrap_sticky_q;
`ifdef LED_PWM_BLINK_EN
    if (sel_blink_c) begin
      rdata_c[CHANNELS-1:0]                        = blink_mask_q;
      rdata_c[BLINK_HALF_LSB +: BLINK_HALF_BITS]   = blink_half_q;
    end
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      if (duty_sel_c[i]) rdata_c[PWM_BITS-1:0] = duty_shadow[i];
    end
  end

  // Registered read data; a colliding write forces 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        rdata_q <= '0;
    else if (bus.read && bus.write) rdata_q <= '0;
    else if (bus.read)              rdata_q <= rdata_c;
  end

  // Per-channel duty, compare and output
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .gen_i        (gen_q),
      .chen_i       (chen_q[i]),
      .wrap_i       (wrap_c),
      .force_off_i  (force_off_c[i]),
      .duty_we_i    (bus.write && duty_sel_c[i]),
      .duty_wdata_i (bus.wdata[PWM_BITS-1:0]),
      .cnt_i        (cnt_q),
      .shadow_o     (duty_shadow[i]),
      .led_n_o      (led_n[i])
    );
  end

  assign bus.rdata   = rdata_q;
  assign period_tick = period_tick_q;
  assign unused_c    = ^{bus.wdata, offset_c};

endmodule

// File: tb/tb_led_pwm_bank.sv
// Scoreboard bench for led_pwm_bank (blink checks when LED_PWM_BLINK_EN is defined).
module tb_led_pwm_bank;
  import led_pwm_pkg::*;

  localparam int unsigned CH   = 3;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] led_n;
  logic          period_tick;

  led_pwm_bank_if bus ();

  led_pwm_bank #(
    .CHANNELS(CH), .PWM_BITS(8), .PRESCALE_BITS(16), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .led_n(led_n), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_lows  [CH];
  int m_falls [CH];
  int m_ticks;
  int exp_blink [6] = '{256, 1, 0, 255, 256, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every read strobe yields rdata on the following cycle
  initial begin : monitor
    rd_exp_t e;
    forever begin
      @(posedge clk);
      if (bus.read === 1'b1) begin
        @(negedge clk);
        if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 32'd1);
        else begin
          e = sb_q.pop_front();
          check(e.name, bus.rdata, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.address = addr; bus.wdata = data; bus.write = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    bus.address = addr; bus.read = 1'b1;
    sb_q.push_back('{name, exp});
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  task automatic wrd(input logic [31:0] addr, input logic [31:0] data, input string name);
    @(posedge clk); #1;
    bus.address = addr; bus.wdata = data; bus.write = 1'b1; bus.read = 1'b1;
    sb_q.push_back('{name, 32'h0});
    @(posedge clk); #1;
    bus.write = 1'b0; bus.read = 1'b0;
  endtask

  // Returns at the negedge where period_tick is seen high
  task automatic wait_tick(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (period_tick !== 1'b1 && k < budget);
    if (period_tick !== 1'b1) check("tick_timeout", 32'(period_tick), 32'd1);
  endtask

  // Sample n consecutive negedges starting now; optional write at sample wr_at
  task automatic measure(input int n, input int wr_at, input logic [31:0] wa, input logic [31:0] wd);
    logic [CH-1:0] prev;
    prev = led_n;
    m_ticks = 0;
    for (int c = 0; c < CH; c++) begin
      m_lows[c] = 0;
      m_falls[c] = 0;
    end
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        bus.address = wa; bus.wdata = wd; bus.write = 1'b1;
      end else if (i == wr_at + 1) begin
        bus.write = 1'b0;
      end
      if (period_tick === 1'b1) m_ticks++;
      for (int c = 0; c < CH; c++) begin
        if (led_n[c] === 1'b0) m_lows[c]++;
        if (prev[c] === 1'b1 && led_n[c] === 1'b0) m_falls[c]++;
      end
      prev = led_n;
      @(negedge clk);
    end
    bus.write = 1'b0;
  endtask

  initial begin : stim
    bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_led_n", 32'(led_n), 32'h7);
    check("reset_period_tick", 32'(period_tick), 32'h0);
    check("reset_rdata", bus.rdata, 32'h0);
    rd(BASE + OFF_CTRL,      32'h0, "rst_ctrl");
    rd(BASE + OFF_STATUS,    32'h0, "rst_status");
    rd(BASE + OFF_DUTY_BASE, 32'h0, "rst_duty0");

    // 25% duty, prescale 0
    wr(BASE + OFF_DUTY_BASE, 32'h40);
    wr(BASE + OFF_PRESCALE,  32'h0);
    wr(BASE + OFF_CTRL,      32'h101);
    wait_tick(600);
    measure(256, -1, 32'h0, 32'h0);
    check("d40_lows",  32'(m_lows[0]),  32'd64);
    check("d40_falls", 32'(m_falls[0]), 32'd1);
    check("d40_ticks", 32'(m_ticks),    32'd1);
    check("d40_ch1_off", 32'(m_lows[1]), 32'd0);

    // Duty change mid-pulse: old pulse completes, new applies next period
    measure(256, 30, BASE + OFF_DUTY_BASE, 32'hC0);
    check("chg_old_lows",  32'(m_lows[0]),  32'd64);
    check("chg_old_falls", 32'(m_falls[0]), 32'd1);
    measure(256, -1, 32'h0, 32'h0);
    check("chg_new_lows",  32'(m_lows[0]),  32'd192);
    check("chg_new_falls", 32'(m_falls[0]), 32'd1);
    check("chg_new_ticks", 32'(m_ticks),    32'd1);
    rd(BASE + OFF_DUTY_BASE, 32'hC0, "duty0_c0");

    // Full-on, full-off, and enabled-but-disabled channel
    wr(BASE + OFF_DUTY_BASE,       32'hFF);
    wr(BASE + OFF_DUTY_BASE + 4,   32'h00);
    wr(BASE + OFF_DUTY_BASE + 8,   32'hFF);
    wr(BASE + OFF_CTRL,            32'h301);
    wait_tick(600);
    wait_tick(600);
    measure(768, -1, 32'h0, 32'h0);
    check("ff_lows",   32'(m_lows[0]),  32'd768);
    check("ff_falls",  32'(m_falls[0]), 32'd0);
    check("d00_lows",  32'(m_lows[1]),  32'd0);
    check("chen_off_lows", 32'(m_lows[2]), 32'd0);
    check("ff_ticks",  32'(m_ticks),    32'd3);

    // STATUS sticky, clear, and clear colliding with wrap
    rd(BASE + OFF_STATUS, 32'h1, "status_set");
    wait_tick(600);
    wr(BASE + OFF_STATUS, 32'h1);
    rd(BASE + OFF_STATUS, 32'h0, "status_clr");
    repeat (250) @(posedge clk);
    wr(BASE + OFF_STATUS, 32'h1);
    rd(BASE + OFF_STATUS, 32'h1, "status_clr_vs_wrap");

    // Simultaneous write and read
    rd(BASE + OFF_CTRL, 32'h301, "ctrl_rb");
    wrd(BASE + OFF_CTRL, 32'h101, "wr_rd_collide");
    rd(BASE + OFF_CTRL, 32'h101, "ctrl_after_collide");

    // Field widths and unmapped accesses
    wr(BASE + OFF_CTRL, 32'hFFFF_FFFF);
    rd(BASE + OFF_CTRL, 32'h0000_0701, "ctrl_mask");
    wr(BASE + OFF_CTRL, 32'h0);
    wr(BASE + OFF_DUTY_BASE, 32'h0000_ABCD);
    rd(BASE + OFF_DUTY_BASE, 32'hCD, "duty_mask");
    wr(BASE + OFF_PRESCALE, 32'hFFFF_0001);
    rd(BASE + OFF_PRESCALE, 32'h1, "prescale_mask");
    wr(BASE + 32'h1C, 32'h55);
    rd(BASE + 32'h1C, 32'h0, "unmapped_duty3");
    wr(32'h0000_0010, 32'h11);
    rd(32'h0000_0010, 32'h0, "outside_window");
    rd(BASE + OFF_DUTY_BASE, 32'hCD, "duty_not_aliased");
    rd(BASE + 32'h100, 32'h0, "unmapped_high");
    wr(BASE + OFF_BLINK, 32'h00FF_0007);
`ifdef LED_PWM_BLINK_EN
    rd(BASE + OFF_BLINK, 32'h00FF_0007, "blink_rb");
`else
    rd(BASE + OFF_BLINK, 32'h0, "blink_absent");
`endif

    // Prescale 1: period doubles to 512 clocks
    wr(BASE + OFF_DUTY_BASE, 32'h40);
    wr(BASE + OFF_CTRL, 32'h101);
    wait_tick(1200);
    measure(1024, -1, 32'h0, 32'h0);
    check("ps1_ticks", 32'(m_ticks),    32'd2);
    check("ps1_lows",  32'(m_lows[0]),  32'd256);
    check("ps1_falls", 32'(m_falls[0]), 32'd2);

`ifdef LED_PWM_BLINK_EN
    // Blink ch0: 2 periods on, 2 off
    wr(BASE + OFF_PRESCALE, 32'h0);
    wr(BASE + OFF_DUTY_BASE, 32'hFF);
    wait_tick(1200);
    wait_tick(600);
    wr(BASE + OFF_BLINK, 32'h0002_0001);
    wait_tick(600);
    for (int w = 0; w < 6; w++) begin
      measure(256, -1, 32'h0, 32'h0);
      check($sformatf("blink_w%0d", w), 32'(m_lows[0]), 32'(exp_blink[w]));
    end
`endif

    // Asynchronous reset while a channel is lit
    wr(BASE + OFF_PRESCALE, 32'h0);
    wr(BASE + OFF_DUTY_BASE + 4, 32'hFF);
    wr(BASE + OFF_CTRL, 32'h201);
    wait_tick(1200);
    wait_tick(600);
    repeat (10) @(negedge clk);
    check("pre_rst_lit", 32'(led_n[1]), 32'h0);
    #2 rst = 1'b1;
    #1 check("async_rst_led_n", 32'(led_n), 32'h7);
    @(negedge clk);
    rst = 1'b0;
    rd(BASE + OFF_CTRL,   32'h0, "post_rst_ctrl");
    rd(BASE + OFF_STATUS, 32'h0, "post_rst_status");
    repeat (20) @(negedge clk);
    check("post_rst_led_n", 32'(led_n), 32'h7);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pwm_bank.md
# led_pwm_bank

Memory-mapped, multi-channel PWM LED controller on the CPU's simple read/write bus. It replaces the fixed single on/off RGB register at 0x8000_0000 with per-channel 8-bit duty registers, a shared prescaler, and glitch-free duty updates. Outputs are active-low and drive the board LEDs directly from the top level.

## Interface
- CHANNELS, 3, number of LED channels (1..16)
- PWM_BITS, 8, duty/counter width (4..16)
- PRESCALE_BITS, 16, prescaler register width
- BASE_ADDR, 32'h8000_0000, byte base address of the register window
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- write  in  1  CPU write request, single-cycle strobe
- read  in  1  CPU read request, single-cycle strobe
- address  in  32  byte address; bits [1:0] ignored
- wdata  in  32  write data (CPU dout)
- rdata  out  32  read data (CPU din), registered
- led_n  out  CHANNELS  PWM outputs, active-low (1 = LED off)
- period_tick  out  1  one-cycle pulse at each PWM period wrap

## Operation
- Register map (byte offsets from BASE_ADDR):
  - 0x00 CTRL: bit0 GEN (global enable); bits [8+CHANNELS-1:8] CHEN (per-channel enable).
  - 0x04 PRESCALE: [PRESCALE_BITS-1:0]; PWM counter advances once every PRESCALE+1 clocks.
  - 0x08 STATUS: bit0 WRAP, sticky; set on period wrap; write 1 clears.
  - 0x0C BLINK (macro-dependent, see Configuration).
  - 0x10+4*i DUTY[i]: [PWM_BITS-1:0] shadow duty of channel i.
- Prescaler counter runs 0..PRESCALE, then emits a tick and returns to 0. The PWM counter (PWM_BITS) increments on each tick and wraps from all-ones to 0; the wrap pulses period_tick.
- At each wrap, every channel copies shadow DUTY into active duty. Duty therefore never changes mid-period.
- A channel is lit (led_n=0) when GEN & CHEN[i] & (cnt < active_duty, or active_duty == all-ones).
  - duty 0: always off.
  - all-ones: always on.
- When GEN=0, the prescaler and counter are held at 0, and active duty loads shadow duty every cycle.
- Unmapped offsets inside or outside the window: reads return 0, writes are ignored. Bits beyond a field's width read 0.
- If write and read are asserted together, the write executes and rdata=0.
- If a STATUS write-1-clear coincides with a wrap, the set wins.

## Timing
- Reset values: all registers 0, led_n all 1, rdata 0, period_tick 0, counters 0.
- Write: the register updates on the clk edge where write=1, visible from the next cycle.
- Read: rdata is valid the cycle after the read strobe and holds until the next read strobe. Reads have no side effects.
- led_n is registered: one cycle latency from the counter/compare state to the pin.
- Period = (PRESCALE+1)·2^PWM_BITS clocks.
- Reset mid-period: outputs go off immediately (asynchronous); operation restarts from count 0 with GEN=0.

## Configuration
- LED_PWM_BLINK_EN defined:
  - BLINK register at 0x0C with mask [CHANNELS-1:0] and half-period [23:16] in PWM periods (0 = blink disabled).
  - A per-module blink counter counts period wraps. Masked channels are forced off during alternate half-periods, starting with the on phase after the BLINK write.
- Without the macro: 0x0C reads 0, writes are ignored, and no blink logic is instantiated.

## Structure
- Package led_pwm_pkg holds:
  - register offset constants (CTRL, PRESCALE, STATUS, BLINK, DUTY_BASE)
  - CTRL bit positions (GEN=0, CHEN_LSB=8)
  - the STATUS WRAP bit index
- Sub-module led_pwm_channel, one instance per channel, holds the shadow/active duty registers, the compare, and the output register. The bank holds decode, prescaler, counter, status and blink.

## Test plan
- Reset, then read 0x00, 0x08, 0x10 -> rdata 0 each; led_n = 3'b111.
- Write DUTY0=0x40, PRESCALE=0, CTRL=0x101 -> led_n[0] low for exactly 64 of every 256 clocks; period_tick every 256 clocks.
- Write DUTY0=0xC0 mid-period -> old 64-clock pulse finishes; the new 192-clock pulse starts at the next wrap; no runt pulse.
- DUTY=0x00 and DUTY=0xFF -> channel constantly off / constantly on across 3 periods.
- Wait for a wrap -> STATUS reads 1. Write 0x1 to 0x08 -> reads 0. A clear coinciding with a wrap -> reads 1.
- With LED_PWM_BLINK_EN: BLINK mask=1, half=2, DUTY0=0xFF -> led_n[0] on 2 periods, off 2 periods, repeating. Without the macro, reading 0x0C returns 0.
